// File: rtl/noc_pkt_if.sv
// Bundle of the packet-request, payload-write and flit-output channels of
// the NoC packet injector. Master is the driving environment, slave the injector.
interface noc_pkt_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2
);
    // Every channel uses valid/ready: a transfer happens on a rising clk edge
    // where valid && ready; the sender holds its payload until that edge.
    logic [3:0]                       msg_dest;
    logic                             msg_valid;
    logic                             msg_ready;
    logic [DATA_WIDTH-TYPE_WIDTH-1:0] payload_data;
    logic                             payload_valid;
    logic                             payload_ready;
    logic [DATA_WIDTH-1:0]            data_out;
    logic                             valid_out;
    logic                             ready_out;
    logic                             busy;
    logic                             pkt_done;

    modport master (
        output msg_dest, msg_valid, payload_data, payload_valid, ready_out,
        input  msg_ready, payload_ready, data_out, valid_out, busy, pkt_done
    );

    modport slave (
        input  msg_dest, msg_valid, payload_data, payload_valid, ready_out,
        output msg_ready, payload_ready, data_out, valid_out, busy, pkt_done
    );
endinterface

// File: rtl/noc_packet_injector.sv
// Builds head/body/tail flit packets from a request plus buffered payload words.
// Optional macro NOC_PKT_SEQ_EN adds an 8-bit sequence number to each head flit.
module noc_packet_injector #(
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int INDEX         = 0,
    parameter int FlitPerPacket = 6,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    noc_pkt_if.slave                    bus,
    output logic                        o_dbg_state,
    output logic [$clog2(FIFO_DEPTH):0] o_dbg_fifo_count
);
    localparam int PW = DATA_WIDTH - TYPE_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FlitPerPacket);
    localparam logic [CW-1:0]         LAST_BODY = CW'(FlitPerPacket - 2);
    localparam logic [TYPE_WIDTH-1:0] T_HEAD    = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] T_BODY    = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL    = TYPE_WIDTH'(2);
    localparam logic [3:0]            NODE_ID   = 4'(INDEX);

    typedef enum logic {IDLE = 1'b0, PAYLOAD = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [PW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [CW-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                r_valid;
    logic                r_tail_q;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          w_seq;
    logic [AW:0]         w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_out_free;
    logic                w_msg_ready;
    logic                w_msg_fire;
    logic                w_pl_load;
    logic                w_is_tail;
    logic                w_tail_fire;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_push      = bus.payload_valid && bus.payload_ready;
    assign w_out_free  = !r_valid || bus.ready_out;
    assign w_msg_ready = rst && (r_state == IDLE) && w_out_free;
    assign w_msg_fire  = bus.msg_valid && w_msg_ready;
    assign w_pl_load   = (r_state == PAYLOAD) && w_out_free && !w_empty;
    assign w_is_tail   = (r_cnt == LAST_BODY);
    assign w_tail_fire = r_valid && bus.ready_out && r_tail_q;
    assign w_head      = {T_HEAD, bus.msg_dest, NODE_ID,
                          {(DATA_WIDTH-TYPE_WIDTH-16){1'b0}}, w_seq};

    assign bus.msg_ready     = w_msg_ready;
    assign bus.payload_ready = rst && !w_full;
    assign bus.data_out      = r_data;
    assign bus.valid_out     = r_valid;
    assign bus.busy          = r_busy;
    assign bus.pkt_done      = r_done;
    assign o_dbg_state       = (r_state == PAYLOAD);
    assign o_dbg_fifo_count  = w_count;

`ifdef NOC_PKT_SEQ_EN
    logic [7:0] r_seq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seq <= '0;
        end else if (w_msg_fire) begin
            r_seq <= r_seq + 8'd1;
        end
    end

    assign w_seq = r_seq;
`else
    assign w_seq = 8'd0;
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_msg_fire) w_state_nx = PAYLOAD;
            PAYLOAD: if (w_pl_load && w_is_tail) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Storage has no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.payload_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_tail_q <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_tail_fire;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pl_load) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_msg_fire) begin
                r_data   <= w_head;
                r_valid  <= 1'b1;
                r_tail_q <= 1'b0;
                r_cnt    <= '0;
            end else if (w_pl_load) begin
                r_data   <= {w_is_tail ? T_TAIL : T_BODY, r_mem[r_rd_ptr[AW-1:0]]};
                r_valid  <= 1'b1;
                r_tail_q <= w_is_tail;
                r_cnt    <= w_is_tail ? '0 : r_cnt + CW'(1);
            end else if (bus.ready_out) begin
                r_valid  <= 1'b0;
                r_tail_q <= 1'b0;
            end
            // A new head accepted alongside the tail transfer keeps busy high.
            if (w_msg_fire) begin
                r_busy <= 1'b1;
            end else if (w_tail_fire) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed + random bench for noc_packet_injector with a flit-stream reference model.
// Set NOC_PKT_SEQ_EN when building to exercise the sequence-number variant.
module tb_noc_packet_injector;
    localparam int FPP    = 6;
    localparam int NPL    = FPP - 1;
    localparam logic [3:0] NODE = 4'd1;

    logic       clk;
    logic       rst;
    logic       dbg_state;
    logic [4:0] dbg_fifo_count;

    noc_pkt_if #(.DATA_WIDTH(32), .TYPE_WIDTH(2)) bus ();

    noc_packet_injector #(
        .DATA_WIDTH(32), .TYPE_WIDTH(2), .INDEX(1),
        .FlitPerPacket(FPP), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .o_dbg_state(dbg_state),
        .o_dbg_fifo_count(dbg_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the flit stream is the requested heads in order, each
    // followed by the next NPL payload words accepted, last one typed as tail.
    logic [31:0] hd_q[$];
    logic [29:0] pl_q[$];
    int          k_pos    = 0;
    logic [7:0]  seq_m    = 8'd0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    bit          mon_en   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    int          n_tails  = 0;
    logic        tail_x;
    logic        have;
    logic [31:0] e_flit;

    always @(negedge clk) begin
        if (mon_en) begin
            tail_x = 1'b0;
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("pkt_done", 32'(bus.pkt_done), 32'(exp_done));
            if (!rst) begin
                hd_q.delete();
                pl_q.delete();
                k_pos = 0;
                seq_m = 8'd0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.valid_out), 32'd1);
                    chk("hold_data", bus.data_out, prev_data);
                end
                if (bus.valid_out && bus.ready_out) begin
                    e_flit = 32'd0;
                    if (k_pos == 0) begin
                        have = (hd_q.size() > 0);
                        if (have) e_flit = hd_q.pop_front();
                    end else begin
                        have = (pl_q.size() > 0);
                        if (have) e_flit = {(k_pos == NPL) ? 2'b10 : 2'b00, pl_q.pop_front()};
                        tail_x = (k_pos == NPL);
                    end
                    chk("flit_expected", 32'(have), 32'd1);
                    chk("flit_data", bus.data_out, e_flit);
                    k_pos = (k_pos == NPL) ? 0 : k_pos + 1;
                    if (tail_x) n_tails++;
                end
                if (bus.msg_valid && bus.msg_ready) begin
                    hd_q.push_back({2'b01, bus.msg_dest, NODE, 14'd0, seq_m});
`ifdef NOC_PKT_SEQ_EN
                    seq_m = seq_m + 8'd1;
`endif
                end
                if (bus.payload_valid && bus.payload_ready) pl_q.push_back(bus.payload_data);
                exp_done = tail_x;
                if (bus.msg_valid && bus.msg_ready) exp_busy = 1'b1;
                else if (tail_x) exp_busy = 1'b0;
                prev_stall = bus.valid_out && !bus.ready_out;
                prev_data  = bus.data_out;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [29:0] w);
        int n;
        logic ok;
        n = 0;
        bus.payload_valid = 1'b1;
        bus.payload_data  = w;
        do begin
            ok = bus.payload_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        bus.payload_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_msg(input logic [3:0] dest);
        int n;
        logic ok;
        n = 0;
        bus.msg_valid = 1'b1;
        bus.msg_dest  = dest;
        do begin
            ok = bus.msg_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        bus.msg_valid = 1'b0;
        chk("msg_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((bus.busy || bus.valid_out) && n < bound) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(bus.busy || bus.valid_out), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        bus.msg_valid = 1'b0;
        bus.payload_valid = 1'b0;
        repeat (cycles) tick();
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int tails0;
        int npkt;
        logic [31:0] hold_d;

        rst = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_dest = 4'd0;
        bus.payload_valid = 1'b0;
        bus.payload_data = '0;
        bus.ready_out = 1'b0;

        // Reset values, and handshake readies low while reset is held.
        tick();
        mon_en = 1'b1;
        tick();
        bus.ready_out = 1'b1;
        bus.payload_valid = 1'b1;
        #1;
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_data_out", bus.data_out, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
        chk("rst_msg_ready", 32'(bus.msg_ready), 32'd0);
        chk("rst_payload_ready", 32'(bus.payload_ready), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_fifo_count", 32'(dbg_fifo_count), 32'd0);
        bus.payload_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Golden packet: payloads 1..5 to node 3, full throughput.
        bus.ready_out = 1'b1;
        for (int i = 1; i <= 5; i++) push_word(30'(i));
        send_msg(4'd3);
        chk("g_head", bus.data_out, 32'h4C40_0000);
        chk("g_head_valid", 32'(bus.valid_out), 32'd1);
        chk("g_state", 32'(dbg_state), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("g_body", bus.data_out, 32'(i));
        end
        tick();
        chk("g_tail", bus.data_out, 32'h8000_0005);
        tick();
        chk("g_valid_after", 32'(bus.valid_out), 32'd0);
        chk("g_pkt_done", 32'(bus.pkt_done), 32'd1);
        chk("g_busy_after", 32'(bus.busy), 32'd0);
        tick();
        chk("g_pkt_done_once", 32'(bus.pkt_done), 32'd0);

        // Head stalled by ready_out=0 for 4 cycles.
        tails0 = n_tails;
        bus.ready_out = 1'b0;
        for (int i = 0; i < NPL; i++) push_word(30'($urandom));
        send_msg(4'($urandom_range(0, 15)));
        hold_d = bus.data_out;
        repeat (4) begin
            tick();
            chk("stall_valid", 32'(bus.valid_out), 32'd1);
            chk("stall_data", bus.data_out, hold_d);
        end
        bus.ready_out = 1'b1;
        wait_idle(50);
        chk("stall_pkt_count", 32'(n_tails), 32'(tails0 + 1));

        // Empty FIFO at request; one word every 3 cycles gives bubbles.
        send_msg(4'd5);
        gaps = 0;
        for (int i = 0; i < NPL; i++) begin
            push_word(30'($urandom));
            tick();
            if (!bus.valid_out) gaps++;
            tick();
            if (!bus.valid_out) gaps++;
        end
        chk("bubble_count", 32'(gaps), 32'd5);
        wait_idle(50);

        // Fill to 16, then push/pop together at 15.
        bus.ready_out = 1'b0;
        for (int i = 0; i < 16; i++) push_word(30'($urandom));
        chk("full_count", 32'(dbg_fifo_count), 32'd16);
        chk("full_ready", 32'(bus.payload_ready), 32'd0);
        bus.payload_valid = 1'b1;
        bus.payload_data = 30'($urandom);
        tick();
        bus.payload_valid = 1'b0;
        chk("full_no_push", 32'(dbg_fifo_count), 32'd16);
        send_msg(4'd7);
        bus.ready_out = 1'b1;
        tick();
        chk("pop_count", 32'(dbg_fifo_count), 32'd15);
        chk("pop_ready", 32'(bus.payload_ready), 32'd1);
        bus.payload_valid = 1'b1;
        bus.payload_data = 30'($urandom);
        tick();
        bus.payload_valid = 1'b0;
        chk("pushpop_count", 32'(dbg_fifo_count), 32'd15);
        do_reset(2);
        chk("flush_count", 32'(dbg_fifo_count), 32'd0);

        // Reset after the third flit transfers.
        for (int i = 0; i < NPL; i++) push_word(30'($urandom));
        send_msg(4'd2);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("mid_valid", 32'(bus.valid_out), 32'd0);
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_count", 32'(dbg_fifo_count), 32'd0);
        chk("mid_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("mid_no_tail", 32'(bus.valid_out), 32'd0);
        end
        for (int i = 0; i < NPL; i++) push_word(30'($urandom));
        send_msg(4'd9);
        chk("mid_fresh_head", bus.data_out, {2'b01, 4'd9, NODE, 14'd0, 8'd0});
        wait_idle(50);

        // Random traffic against the model.
        repeat (800) begin
            bus.payload_valid = ($urandom_range(0, 3) != 0);
            bus.payload_data  = 30'($urandom);
            bus.msg_valid     = ($urandom_range(0, 3) == 0);
            bus.msg_dest      = 4'($urandom_range(0, 15));
            bus.ready_out     = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.msg_valid = 1'b0;
        bus.ready_out = 1'b1;
        for (int n = 0; n < 300 && (bus.busy || bus.valid_out); n++) begin
            bus.payload_valid = bus.busy;
            bus.payload_data  = 30'($urandom);
            tick();
        end
        bus.payload_valid = 1'b0;
        tick();
        chk("drain_heads", 32'(hd_q.size()), 32'd0);
        chk("drain_phase", 32'(k_pos), 32'd0);

        // Head sequence field over many packets.
        do_reset(2);
`ifdef NOC_PKT_SEQ_EN
        npkt = 257;
`else
        npkt = 3;
`endif
        for (int p = 0; p < npkt; p++) begin
            for (int i = 0; i < NPL; i++) push_word(30'($urandom));
            send_msg(4'(p));
`ifdef NOC_PKT_SEQ_EN
            chk("head_seq", 32'(bus.data_out[7:0]), 32'(p % 256));
`else
            chk("head_seq", 32'(bus.data_out[7:0]), 32'd0);
`endif
            wait_idle(40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
